// File: rtl/rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : rvfi_commit_serializer
//  Description : Merges multi-port RVFI commits into one ordered FIFO stream,
//                stopping after an ECALL has drained out to the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================

package rvfi_commit_serializer_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;

endpackage

module rvfi_commit_serializer
    import rvfi_commit_serializer_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DROP_CNT_W      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
    output rvfi_instr_t                         rvfi_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [$clog2(DEPTH):0]              level_o,
    output logic [DROP_CNT_W-1:0]               drop_cnt_o,
    output logic                                overflow_o,
    output logic                                halt_o
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_lvl_w = c_ptr_w + 1;
    localparam int unsigned c_cnt_w = $clog2(NR_COMMIT_PORTS + 1);
    localparam logic [31:0] c_ecall = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e                     r_state;
    state_e                     w_state_next;

    rvfi_instr_t                r_mem [DEPTH];
    rvfi_instr_t                r_head;
    rvfi_instr_t                w_head_next;
    logic [c_ptr_w-1:0]         r_wptr;
    logic [c_ptr_w-1:0]         r_rptr;
    logic [c_ptr_w-1:0]         w_rptr_next;
    logic [c_lvl_w-1:0]         r_level;
    logic [c_lvl_w-1:0]         w_level_next;
    logic [c_lvl_w-1:0]         w_free;
    logic [c_lvl_w-1:0]         w_acc_n;
    logic [c_cnt_w-1:0]         w_drop_n;
    logic [DROP_CNT_W-1:0]      r_drop_cnt;
    logic [DROP_CNT_W:0]        w_drop_sum;
    logic                       r_overflow;
    logic                       w_pop;
    logic                       w_ecall_acc;
    logic [NR_COMMIT_PORTS-1:0] w_wr_en;
    logic [c_ptr_w-1:0]         w_wr_addr [NR_COMMIT_PORTS];

    assign w_pop  = valid_o & ready_i;
    assign w_free = c_lvl_w'(DEPTH) - r_level + c_lvl_w'(w_pop);

    // Compacting admission: eligible ports take consecutive free slots in port
    // order; anything past an accepted ECALL is silently discarded.
    always_comb begin
        w_acc_n     = '0;
        w_drop_n    = '0;
        w_ecall_acc = 1'b0;
        w_wr_en     = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_wr_addr[i] = r_wptr + w_acc_n[c_ptr_w-1:0];
            if ((r_state == ST_RUN) && !w_ecall_acc &&
                (rvfi_i[i].valid || rvfi_i[i].trap)) begin
                if (w_acc_n < w_free) begin
                    w_wr_en[i] = 1'b1;
                    w_acc_n    = w_acc_n + c_lvl_w'(1);
                    if (rvfi_i[i].valid && (rvfi_i[i].insn == c_ecall)) begin
                        w_ecall_acc = 1'b1;
                    end
                end else begin
                    w_drop_n = w_drop_n + c_cnt_w'(1);
                end
            end
        end
    end

    assign w_level_next = r_level + w_acc_n - c_lvl_w'(w_pop);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'(w_drop_n);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_ecall_acc) begin
                    w_state_next = ST_DRAIN;
                end
            end
            // The ECALL is the youngest buffered record, so the last pop is it.
            ST_DRAIN: begin
                if (w_pop && (r_level == c_lvl_w'(1))) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Next head: a record written this cycle into the new read slot bypasses
    // the array so the output can stay a plain register.
    always_comb begin
        w_rptr_next = r_rptr + c_ptr_w'(w_pop);
        w_head_next = r_mem[w_rptr_next];
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (w_wr_en[i] && (w_wr_addr[i] == w_rptr_next)) begin
                w_head_next = rvfi_i[i];
            end
        end
        if ((w_level_next == '0) || (w_state_next == ST_HALTED)) begin
            w_head_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_RUN;
            r_head     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_wptr  <= r_wptr + w_acc_n[c_ptr_w-1:0];
            r_rptr  <= w_rptr_next;
            r_level <= w_level_next;
            if (w_drop_n != '0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (w_wr_en[i]) begin
                r_mem[w_wr_addr[i]] <= rvfi_i[i];
            end
        end
    end

    assign rvfi_o     = r_head;
    assign valid_o    = (r_level != '0);
    assign level_o    = r_level;
    assign drop_cnt_o = r_drop_cnt;
    assign overflow_o = r_overflow;
    assign halt_o     = (r_state == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvfi_commit_serializer
//  Description : Directed bench with a pc scoreboard for rvfi_commit_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_rvfi_commit_serializer;
    import rvfi_commit_serializer_pkg::*;

    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 16;
    localparam logic [31:0] c_nop   = 32'h0000_0013;
    localparam logic [31:0] c_ecall = 32'h0000_0073;

    logic                 clk    = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 ready  = 1'b0;
    rvfi_instr_t [NP-1:0] rvfi_in;
    rvfi_instr_t          rvfi_out;
    logic                 valid;
    logic [3:0]           level;
    logic [DW-1:0]        drop_cnt;
    logic                 overflow;
    logic                 halt;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (NP),
        .DEPTH           (DEPTH),
        .DROP_CNT_W      (DW)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rvfi_i     (rvfi_in),
        .rvfi_o     (rvfi_out),
        .valid_o    (valid),
        .ready_i    (ready),
        .level_o    (level),
        .drop_cnt_o (drop_cnt),
        .overflow_o (overflow),
        .halt_o     (halt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input int p, input logic v, input logic t,
                         input logic [31:0] pc, input logic [31:0] insn);
        rvfi_in[p]          = '0;
        rvfi_in[p].valid    = v;
        rvfi_in[p].trap     = t;
        rvfi_in[p].pc_rdata = pc;
        rvfi_in[p].pc_wdata = pc + 32'd4;
        rvfi_in[p].insn     = insn;
    endtask

    task automatic idle();
        rvfi_in = '0;
    endtask

    // Scoreboard: every handshake pops the oldest expected pc.
    always @(negedge clk) begin
        if (rst_ni && valid && ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("sb_pc", 64'(rvfi_out.pc_rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rvfi_in = '0;
        #2;
        check("rst_valid",    64'(valid),            64'd0);
        check("rst_level",    64'(level),            64'd0);
        check("rst_drop",     64'(drop_cnt),         64'd0);
        check("rst_overflow", 64'(overflow),         64'd0);
        check("rst_halt",     64'(halt),             64'd0);
        check("rst_rvfi_o",   64'(rvfi_out != '0),   64'd0);
        cyc(2);
        rst_ni = 1'b1;
        cyc(1);

        // Two valid records in one cycle, consumer always ready
        ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8000_0000, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_0004, c_nop);
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0004);
        cyc(1);
        idle();
        check("t1_level2",  64'(level),             64'd2);
        check("t1_valid",   64'(valid),             64'd1);
        check("t1_head0",   64'(rvfi_out.pc_rdata), 64'h8000_0000);
        cyc(1);
        check("t1_level1",  64'(level),             64'd1);
        check("t1_head1",   64'(rvfi_out.pc_rdata), 64'h8000_0004);
        cyc(1);
        check("t1_level0",  64'(level),             64'd0);
        check("t1_invalid", 64'(valid),             64'd0);

        // Port 0 ineligible, port 1 valid; then a trap-only record
        ready = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0000_1234, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_0008, c_nop);
        exp_q.push_back(32'h8000_0008);
        cyc(1);
        idle();
        check("t2_level",   64'(level),             64'd1);
        check("t2_head",    64'(rvfi_out.pc_rdata), 64'h8000_0008);
        drive(0, 1'b0, 1'b1, 32'h8000_000C, c_nop);
        exp_q.push_back(32'h8000_000C);
        cyc(1);
        idle();
        check("t2_trap_lvl", 64'(level),            64'd2);
        ready = 1'b1;
        cyc(1);
        check("t2_trap_head", 64'(rvfi_out.trap),   64'd1);
        cyc(1);
        check("t2_empty",   64'(level),             64'd0);

        // Fill with consumer stalled: 10 offered, 8 accepted
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 1'b0, 32'h8000_1000 + 32'(8 * k),     c_nop);
            drive(1, 1'b1, 1'b0, 32'h8000_1000 + 32'(8 * k + 4), c_nop);
            if (k < 4) begin
                exp_q.push_back(32'h8000_1000 + 32'(8 * k));
                exp_q.push_back(32'h8000_1000 + 32'(8 * k + 4));
            end
            cyc(1);
            check("t3_hold", 64'(rvfi_out.pc_rdata), 64'h8000_1000);
        end
        idle();
        check("t3_level",   64'(level),    64'd8);
        check("t3_drop",    64'(drop_cnt), 64'd2);
        check("t3_ovf",     64'(overflow), 64'd1);
        check("t3_valid",   64'(valid),    64'd1);

        // Full FIFO, pop plus two pushes: one accepted, one dropped
        ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8000_2000, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_2004, c_nop);
        exp_q.push_back(32'h8000_2000);
        cyc(1);
        idle();
        ready = 1'b0;
        check("t4_level",   64'(level),             64'd8);
        check("t4_drop",    64'(drop_cnt),          64'd3);
        check("t4_head",    64'(rvfi_out.pc_rdata), 64'h8000_1004);
        ready = 1'b1;
        cyc(8);
        check("t4_level0",  64'(level),             64'd0);
        check("t4_sb_done", 64'(exp_q.size()),      64'd0);

        // ECALL with three older records buffered
        ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h8000_3000, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_3004, c_nop);
        exp_q.push_back(32'h8000_3000);
        exp_q.push_back(32'h8000_3004);
        cyc(1);
        idle();
        drive(0, 1'b1, 1'b0, 32'h8000_3008, c_nop);
        exp_q.push_back(32'h8000_3008);
        cyc(1);
        idle();
        drive(0, 1'b1, 1'b0, 32'h8000_300C, c_ecall);
        drive(1, 1'b1, 1'b0, 32'h8000_3010, c_nop);
        exp_q.push_back(32'h8000_300C);
        cyc(1);
        check("t5_level4",  64'(level),    64'd4);
        check("t5_nodrop",  64'(drop_cnt), 64'd3);
        drive(0, 1'b1, 1'b0, 32'h8000_9000, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_9004, c_nop);
        ready = 1'b1;
        cyc(3);
        check("t5_lvl_last", 64'(level),   64'd1);
        check("t5_not_halt", 64'(halt),    64'd0);
        cyc(1);
        check("t5_halt",    64'(halt),     64'd1);
        check("t5_empty",   64'(level),    64'd0);
        cyc(3);
        check("t5_ignored", 64'(level),    64'd0);
        check("t5_novalid", 64'(valid),    64'd0);
        check("t5_halt_stk", 64'(halt),    64'd1);
        check("t5_drop_stk", 64'(drop_cnt), 64'd3);
        check("t5_sb_done", 64'(exp_q.size()), 64'd0);
        idle();

        // Leave HALTED, re-enter DRAIN with three records, reset asynchronously
        rst_ni = 1'b0;
        cyc(1);
        rst_ni = 1'b1;
        ready  = 1'b0;
        cyc(1);
        check("t6_unhalt",  64'(halt),     64'd0);
        drive(0, 1'b1, 1'b0, 32'h8000_4000, c_nop);
        drive(1, 1'b1, 1'b0, 32'h8000_4004, c_nop);
        cyc(1);
        idle();
        drive(0, 1'b1, 1'b0, 32'h8000_4008, c_ecall);
        cyc(1);
        idle();
        check("t6_level3",  64'(level),    64'd3);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_level", 64'(level),          64'd0);
        check("t6_rst_valid", 64'(valid),          64'd0);
        check("t6_rst_rvfi",  64'(rvfi_out != '0), 64'd0);
        check("t6_rst_drop",  64'(drop_cnt),       64'd0);
        check("t6_rst_ovf",   64'(overflow),       64'd0);
        check("t6_rst_halt",  64'(halt),           64'd0);
        cyc(1);
        rst_ni = 1'b1;
        ready  = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8000_5000, c_nop);
        exp_q.push_back(32'h8000_5000);
        cyc(1);
        idle();
        check("t6_new_level", 64'(level),             64'd1);
        check("t6_new_head",  64'(rvfi_out.pc_rdata), 64'h8000_5000);
        cyc(1);
        check("t6_drained",   64'(level),             64'd0);
        check("t6_sb_done",   64'(exp_q.size()),      64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
